// File: rtl/sr_exc_pkg.sv
// Shared types and helpers for the SR flip-flop exciter.
// Optional capture feature: SR_EXC_CAPTURE_EN.
package sr_exc_pkg;

   typedef enum logic [2:0] {
      INIT0,
      INIT1,
      IDLE,
      DRIVE,
      CHECK
   } state_t;

   localparam logic [1:0] HOLD = 2'b00;

   // {S,R} needed to move a clocked SR flip-flop from q_cur to q_next
   function automatic logic [1:0] sr_excite(input logic q_cur,
                                            input logic q_next);
      if (q_cur == q_next) return HOLD;
      return q_next ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sr_exc_counter.sv
// Clearable counter that either wraps or saturates at all-ones.
// Used for vector and mismatch counts of sr_ff_exciter.
module sr_exc_counter
   import sr_exc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic         sat,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !(sat && (&cnt))) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sr_ff_exciter.sv
// Drives an external clocked SR flip-flop from a target-Q stream and checks Q.
// Define SR_EXC_CAPTURE_EN to add first-mismatch capture (err_idx, err_exp).
module sr_ff_exciter
   import sr_exc_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             tgt_valid,
   input  logic             tgt_bit,
   output logic             tgt_ready,
   input  logic             cnt_clr,
   input  logic             q_fb,
   output logic             S,
   output logic             R,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_flag,
   output logic             init_done
`ifdef SR_EXC_CAPTURE_EN
   ,
   output logic [CNT_W-1:0] err_idx,
   output logic             err_exp
`endif
);

   state_t state, nstate;
   logic   exp_q, exp_nx;
   logic   q_exp, qexp_nx;
   logic   s_nx, r_nx, done_nx;
   logic   chk, init_chk, mism;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= INIT0;
         S         <= 1'b0;
         R         <= 1'b0;
         exp_q     <= 1'b0;
         q_exp     <= 1'b0;
         init_done <= 1'b0;
         err_flag  <= 1'b0;
      end else begin
         state     <= nstate;
         S         <= s_nx;
         R         <= r_nx;
         exp_q     <= exp_nx;
         q_exp     <= qexp_nx;
         init_done <= done_nx;
         if (cnt_clr) err_flag <= 1'b0;
         else if (mism) err_flag <= 1'b1;
      end
   end

   // INIT0 spends two cycles: raise R, then drop it as the flop captures
   always_comb begin
      nstate   = state;
      s_nx     = 1'b0;
      r_nx     = 1'b0;
      exp_nx   = exp_q;
      qexp_nx  = q_exp;
      done_nx  = init_done;
      chk      = 1'b0;
      init_chk = 1'b0;
      unique case (state)
         INIT0: begin
            r_nx = ~R;
            if (R) nstate = INIT1;
         end
         INIT1: begin
            init_chk = 1'b1;
            done_nx  = 1'b1;
            nstate   = IDLE;
         end
         IDLE: begin
            if (tgt_valid) begin
               {s_nx, r_nx} = sr_excite(q_exp, tgt_bit);
               exp_nx       = tgt_bit;
               nstate       = DRIVE;
            end
         end
         DRIVE: begin
            nstate = CHECK;
         end
         CHECK: begin
            chk     = 1'b1;
            qexp_nx = exp_q;
            nstate  = IDLE;
         end
         default: nstate = INIT0;
      endcase
   end

   assign tgt_ready = (state == IDLE);
   assign mism      = (init_chk & q_fb) | (chk & (q_fb != exp_q));

   sr_exc_counter #(.W(CNT_W)) u_vec (
      .clk (CLK),
      .rst (RST),
      .clr (cnt_clr),
      .inc (chk),
      .sat (1'b0),
      .cnt (vec_cnt)
   );

   sr_exc_counter #(.W(CNT_W)) u_err (
      .clk (CLK),
      .rst (RST),
      .clr (cnt_clr),
      .inc (mism),
      .sat (1'b1),
      .cnt (err_cnt)
   );

`ifdef SR_EXC_CAPTURE_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         err_idx <= '0;
         err_exp <= 1'b0;
      end else if (cnt_clr) begin
         err_idx <= '0;
         err_exp <= 1'b0;
      end else if (mism && !err_flag) begin
         err_idx <= init_chk ? '0 : vec_cnt;
         err_exp <= init_chk ? 1'b0 : exp_q;
      end
   end
`endif

endmodule

// File: tb/tb_sr_ff_exciter.sv
// Self-checking bench for sr_ff_exciter against a clocked SR flip-flop plant.
// Honours SR_EXC_CAPTURE_EN when the design is built with it.
module tb_sr_ff_exciter;

   localparam int W    = 8;
   localparam int MAXV = (1 << W) - 1;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         tgt_valid = 1'b0;
   logic         tgt_bit = 1'b0;
   logic         cnt_clr = 1'b0;
   logic         q_fb;
   logic         tgt_ready, S, R, err_flag, init_done;
   logic [W-1:0] vec_cnt, err_cnt;
`ifdef SR_EXC_CAPTURE_EN
   logic [W-1:0] err_idx;
   logic         err_exp;
`endif

   // plant: clocked SR flip-flop, powers up at 1, S input can be stuck low
   logic ffq = 1'b1;
   bit   stuck = 1'b0;

   int total = 0;
   int bad = 0;
   int vec_m, err_m, cap_idx;
   bit prev_m, ffm, cap_exp;

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (R) ffq <= 1'b0;
      else if (S && !stuck) ffq <= 1'b1;
   end

   assign q_fb = ffq;

   sr_ff_exciter #(.CNT_W(W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .tgt_valid (tgt_valid),
      .tgt_bit   (tgt_bit),
      .tgt_ready (tgt_ready),
      .cnt_clr   (cnt_clr),
      .q_fb      (q_fb),
      .S         (S),
      .R         (R),
      .vec_cnt   (vec_cnt),
      .err_cnt   (err_cnt),
      .err_flag  (err_flag),
      .init_done (init_done)
`ifdef SR_EXC_CAPTURE_EN
      ,
      .err_idx   (err_idx),
      .err_exp   (err_exp)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      vec_m   = 0;
      err_m   = 0;
      cap_idx = 0;
      cap_exp = 1'b0;
   endtask

   task automatic reset_model();
      clear_model();
      prev_m = 1'b0;
      ffm    = 1'b0;
   endtask

   task automatic chk_counts();
      chk("vec_cnt", vec_cnt, vec_m % (MAXV + 1));
      chk("err_cnt", err_cnt, (err_m > MAXV) ? MAXV : err_m);
      chk("err_flag", err_flag, err_m > 0);
`ifdef SR_EXC_CAPTURE_EN
      chk("err_idx", err_idx, cap_idx);
      chk("err_exp", err_exp, cap_exp);
`endif
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!tgt_ready && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk("ready_wait", tgt_ready, 1);
   endtask

   // after RST release: R high one cycle, done two cycles later, then ready
   task automatic init_check();
      int rat = -1;
      int dat = -1;
      int yat = -1;
      int rc = 0;
      int sc = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (R) begin
            rc++;
            if (rat < 0) rat = i;
         end
         if (S) sc++;
         if (init_done && dat < 0) dat = i;
         if (tgt_ready && yat < 0) yat = i;
      end
      chk("init_r_cycles", rc, 1);
      chk("init_s_cycles", sc, 0);
      chk("init_done_lat", dat - rat, 2);
      chk("init_ready_at", yat, dat);
      chk("init_done", init_done, 1);
      chk("init_err_flag", err_flag, 0);
   endtask

   // one vector; expected S/R come from the excitation rule on the model Q
   task automatic send(input bit t, input bit hold);
      wait_ready();
      tgt_bit   = t;
      tgt_valid = 1'b1;
      @(negedge CLK);
      chk("S_drive", S, (t == 1'b1 && prev_m == 1'b0));
      chk("R_drive", R, (t == 1'b0 && prev_m == 1'b1));
      chk("rdy_drive", tgt_ready, 0);
      if (!hold) tgt_valid = 1'b0;
      @(negedge CLK);
      chk("S_rel", S, 0);
      chk("R_rel", R, 0);
      chk("rdy_check", tgt_ready, 0);
      if (!t) ffm = 1'b0;
      else if (!stuck) ffm = 1'b1;
      if (ffm != t) begin
         if (err_m == 0) begin
            cap_idx = vec_m % (MAXV + 1);
            cap_exp = t;
         end
         err_m++;
      end
      vec_m++;
      prev_m = t;
      @(negedge CLK);
      chk("rdy_back", tgt_ready, 1);
      chk_counts();
   endtask

   initial begin
      bit d [5];
      d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      reset_model();
      repeat (3) @(negedge CLK);
      chk("rst_S", S, 0);
      chk("rst_R", R, 0);
      chk("rst_ready", tgt_ready, 0);
      chk("rst_done", init_done, 0);
      chk_counts();
      RST = 1'b0;
      init_check();

      for (int i = 0; i < 5; i++) send(d[i], 1'b1);
      tgt_valid = 1'b0;
      chk("dir_vec5", vec_cnt, 5);
      chk("dir_err0", err_cnt, 0);

      repeat (30) begin
         send(1'($urandom_range(0, 1)), 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end

      send(1'b0, 1'b0);
      stuck   = 1'b1;
      cnt_clr = 1'b1;
      @(negedge CLK);
      cnt_clr = 1'b0;
      clear_model();
      chk_counts();
      send(1'b1, 1'b0);
      chk("stuck_err1", err_cnt, 1);
      chk("stuck_flag", err_flag, 1);

      wait_ready();
      tgt_bit   = 1'b1;
      tgt_valid = 1'b1;
      @(negedge CLK);
      tgt_valid = 1'b0;
      chk("clr_S_hold", S, 0);
      chk("clr_R_hold", R, 0);
      @(negedge CLK);
      cnt_clr = 1'b1;
      @(negedge CLK);
      cnt_clr = 1'b0;
      clear_model();
      prev_m = 1'b1;
      chk("clr_vec", vec_cnt, 0);
      chk("clr_err", err_cnt, 0);
      chk("clr_flag", err_flag, 0);

      repeat (MAXV + 3) send(1'b1, 1'b0);
      chk("sat_err", err_cnt, MAXV);
      chk("wrap_vec", vec_cnt, 2);
      repeat (10) send(1'($urandom_range(0, 1)), 1'b0);

      stuck = 1'b0;
      RST   = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      reset_model();
      init_check();
      wait_ready();
      tgt_bit   = 1'b1;
      tgt_valid = 1'b1;
      @(negedge CLK);
      tgt_valid = 1'b0;
      chk("mid_S_high", S, 1);
      #2 RST = 1'b1;
      #1;
      chk("mid_S_drop", S, 0);
      chk("mid_R_drop", R, 0);
      chk("mid_ready", tgt_ready, 0);
      chk("mid_vec", vec_cnt, 0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      reset_model();
      init_check();
      chk("post_vec", vec_cnt, 0);
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
